// File: rtl/main_memory_ctrl.sv
// Block-granular backing store behind the set-associative cache: one outstanding
// read-fill or write-back at a time, fixed latency, saturating access counters.
module main_memory_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int BLOCK_W  = 128,
  parameter int OFFSET_W = 4,
  parameter int LATENCY  = 4,
  parameter int CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_row_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [BLOCK_W-1:0] req_wdata_i,
  output logic               resp_valid_o,
  output logic               resp_row_o,
  output logic [BLOCK_W-1:0] resp_rdata_o,
  output logic [CNT_W-1:0]   rd_count_o,
  output logic [CNT_W-1:0]   wr_count_o
);

  localparam int IDX_W = ADDR_W - OFFSET_W;
  localparam int DEPTH = 1 << IDX_W;
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state_q;
  logic [LAT_W-1:0]   cnt_q;
  logic               row_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic               ready_q;
  logic               resp_valid_q;
  logic               resp_row_q;
  logic [BLOCK_W-1:0] rdata_q;
  logic [CNT_W-1:0]   rd_cnt_q;
  logic [CNT_W-1:0]   wr_cnt_q;

  // NOTE: the array and its written flags have no reset; rst must never disturb
  // stored blocks. Unwritten entries read back their power-up pattern instead.
  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]   written_q = '0;

  logic               complete;
  logic               wr_commit;
  logic [BLOCK_W-1:0] rd_block;
  logic               unused_offset;

  // Power-up content: every byte holds the low 8 bits of its own byte address.
  function automatic logic [BLOCK_W-1:0] init_block(input logic [IDX_W-1:0] idx);
    init_block = '0;
    for (int i = 0; i < BLOCK_W / 8; i++) begin
      init_block[8*i +: 8] = 8'({idx, OFFSET_W'(i)});
    end
  endfunction

  assign unused_offset = ^req_addr_i[OFFSET_W-1:0];
  assign complete      = (state_q == BUSY) && (cnt_q == '0);
  assign wr_commit     = complete && row_q && !rst_i;

  always_comb begin
    rd_block = init_block(idx_q);
    if (written_q[idx_q]) rd_block = mem_q[idx_q];
  end

  always_ff @(posedge clk_i) begin
    if (wr_commit) begin
      mem_q[idx_q]     <= wdata_q;
      written_q[idx_q] <= 1'b1;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_row_q   <= 1'b0;
      rdata_q      <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            row_q   <= req_row_i;
            idx_q   <= req_addr_i[ADDR_W-1:OFFSET_W];
            wdata_q <= req_wdata_i;
            cnt_q   <= LAT_W'(LATENCY - 1);
            ready_q <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_row_q   <= row_q;
            if (row_q) begin
              if (wr_cnt_q != {CNT_W{1'b1}}) wr_cnt_q <= wr_cnt_q + 1'b1;
            end else begin
              rdata_q <= rd_block;
              if (rd_cnt_q != {CNT_W{1'b1}}) rd_cnt_q <= rd_cnt_q + 1'b1;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_row_o   = resp_row_q;
  assign resp_rdata_o = rdata_q;
  assign rd_count_o   = rd_cnt_q;
  assign wr_count_o   = wr_cnt_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl: a LATENCY=4 instance for timing, abort and
// hold-off cases, and a LATENCY=1 / 2-bit-counter instance for saturation and a model sweep.
module tb_main_memory_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_row = 1'b0;
  logic [9:0]   req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         use_b = 1'b0;

  logic         a_ready, a_resp_valid, a_resp_row;
  logic [127:0] a_rdata;
  logic [15:0]  a_rd_count, a_wr_count;
  logic         b_ready, b_resp_valid, b_resp_row;
  logic [127:0] b_rdata;
  logic [1:0]   b_rd_count, b_wr_count;

  logic         cur_ready, cur_resp_valid, cur_resp_row;
  logic [127:0] cur_rdata;
  logic [15:0]  cur_rd_count, cur_wr_count;

  int n_chk = 0;
  int n_err = 0;
  int edge_n = 0;
  int last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  main_memory_ctrl dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && !use_b), .req_ready_o(a_ready),
    .req_row_i(req_row), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(a_resp_valid), .resp_row_o(a_resp_row), .resp_rdata_o(a_rdata),
    .rd_count_o(a_rd_count), .wr_count_o(a_wr_count)
  );

  main_memory_ctrl #(.LATENCY(1), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && use_b), .req_ready_o(b_ready),
    .req_row_i(req_row), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(b_resp_valid), .resp_row_o(b_resp_row), .resp_rdata_o(b_rdata),
    .rd_count_o(b_rd_count), .wr_count_o(b_wr_count)
  );

  assign cur_ready      = use_b ? b_ready : a_ready;
  assign cur_resp_valid = use_b ? b_resp_valid : a_resp_valid;
  assign cur_resp_row   = use_b ? b_resp_row : a_resp_row;
  assign cur_rdata      = use_b ? b_rdata : a_rdata;
  assign cur_rd_count   = use_b ? {14'b0, b_rd_count} : a_rd_count;
  assign cur_wr_count   = use_b ? {14'b0, b_wr_count} : a_wr_count;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge with the controller back in IDLE.
  task automatic txn(input logic row, input logic [9:0] addr, input logic [127:0] wdata,
                     input int lat, input string tag, output logic [127:0] rdata);
    int k;
    int w;
    req_row = row; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    w = 0;
    while (!cur_ready && w < 50) begin @(negedge clk); w++; end
    check({tag, "_ready"}, cur_ready, 1'b1);
    @(negedge clk);
    k = edge_n;
    req_valid = 1'b0; req_row = ~row; req_addr = ~addr; req_wdata = ~wdata;
    w = 0;
    while (!cur_resp_valid && w < 50) begin @(negedge clk); w++; end
    check({tag, "_lat"}, edge_n - k, lat);
    check({tag, "_row"}, cur_resp_row, row);
    rdata = cur_rdata;
    @(negedge clk);
    check({tag, "_pulse"}, cur_resp_valid, 1'b0);
    last_acc = k;
  endtask

  logic [127:0] rd;
  logic [127:0] model [64];
  int           k0, k1;
  bit           seen;
  logic [5:0]   r, w_idx, prev_w;
  logic [127:0] d;

  initial begin
    do_reset();
    // Reset state
    check("rst_ready", a_ready, 1'b1);
    check("rst_resp_valid", a_resp_valid, 1'b0);
    check("rst_resp_row", a_resp_row, 1'b0);
    check("rst_rdata", a_rdata, '0);
    check("rst_rd_count", a_rd_count, 16'd0);
    check("rst_wr_count", a_wr_count, 16'd0);

    // 1: read fill of initial content
    txn(1'b0, 10'h013, '0, 4, "t1", rd);
    check("t1_data", rd, 128'h1F1E1D1C1B1A19181716151413121110);
    check("t1_rd_count", a_rd_count, 16'd1);

    // 2: write-back then read of the same block, back to back
    do_reset();
    txn(1'b1, 10'h3F0, {16{8'hA5}}, 4, "t2w", rd);
    k0 = last_acc;
    check("t2w_rdata_held", rd, '0);
    txn(1'b0, 10'h3F5, '0, 4, "t2r", rd);
    check("t2_accept_gap", last_acc - k0, 6);
    check("t2_data", rd, {16{8'hA5}});
    check("t2_wr_count", a_wr_count, 16'd1);
    check("t2_rd_count", a_rd_count, 16'd1);

    // 3: request held high while busy, address wandering
    req_row = 1'b0; req_addr = 10'h025; req_valid = 1'b1;
    check("t3_ready0", a_ready, 1'b1);
    @(negedge clk);
    k0 = edge_n;
    for (int i = 0; i < 5; i++) begin
      check("t3_busy_ready", a_ready, 1'b0);
      if (i == 4) begin
        check("t3_resp1", a_resp_valid, 1'b1);
        check("t3_data1", a_rdata, 128'h2F2E2D2C2B2A29282726252423222120);
      end
      req_addr = (i == 4) ? 10'h036 : 10'(10'h100 + i * 16);
      @(negedge clk);
    end
    check("t3_idle_ready", a_ready, 1'b1);
    @(negedge clk);
    k1 = edge_n;
    check("t3_second_accept", a_ready, 1'b0);
    check("t3_accept_gap", k1 - k0, 6);
    req_valid = 1'b0;
    for (int i = 0; i < 50 && !a_resp_valid; i++) @(negedge clk);
    check("t3_lat2", edge_n - k1, 4);
    check("t3_data2", a_rdata, 128'h3F3E3D3C3B3A39383736353433323130);
    check("t3_rd_count", a_rd_count, 16'd3);
    @(negedge clk);

    // 4: reset aborts an in-flight write
    req_row = 1'b1; req_addr = 10'h020; req_wdata = {16{8'h5A}}; req_valid = 1'b1;
    for (int i = 0; i < 50 && !a_ready; i++) @(negedge clk);
    check("t4_ready", a_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    seen |= a_resp_valid;
    @(negedge clk);
    seen |= a_resp_valid;
    rst = 1'b1;
    repeat (2) begin @(negedge clk); seen |= a_resp_valid; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); seen |= a_resp_valid; end
    check("t4_no_resp", seen, 1'b0);
    check("t4_wr_count", a_wr_count, 16'd0);
    txn(1'b0, 10'h020, '0, 4, "t4r", rd);
    check("t4_data", rd, 128'h2F2E2D2C2B2A29282726252423222120);
    txn(1'b0, 10'h3F0, '0, 4, "t4k", rd);
    check("t4_kept_after_rst", rd, {16{8'hA5}});
    check("t4_rd_count", a_rd_count, 16'd2);

    // 5/6: LATENCY=1 sweep against a reference model; 2-bit counters saturate at 3
    do_reset();
    use_b = 1'b1;
    for (int idx = 0; idx < 64; idx++)
      for (int i = 0; i < 16; i++)
        model[idx][8*i +: 8] = 8'(idx * 16 + i);
    prev_w = 6'd0;
    for (int n = 0; n < 64; n++) begin
      r = (n % 2 == 1) ? prev_w : 6'($urandom_range(0, 63));
      txn(1'b0, {r, 4'($urandom_range(0, 15))}, '0, 1, "t6r", rd);
      check("t6_rdata", rd, model[r]);
      if (n == 1) check("t5_rd_count_2", cur_rd_count, 16'd2);
      w_idx = 6'($urandom_range(0, 63));
      d = {$urandom, $urandom, $urandom, $urandom};
      txn(1'b1, {w_idx, 4'h0}, d, 1, "t6w", rd);
      model[w_idx] = d;
      prev_w = w_idx;
    end
    txn(1'b0, {prev_w, 4'h9}, '0, 1, "t6last", rd);
    check("t6_last_data", rd, model[prev_w]);
    check("t5_rd_sat", cur_rd_count, 16'd3);
    check("t5_wr_sat", cur_wr_count, 16'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
